// File: rtl/slant_cap_sched.sv
// slant_cap_sched: capture scheduler for the four-bank slant frame buffer.
// It watches the AXI4-Stream video sideband in the camera clock domain and
// opens the write path on a frame boundary for a programmed number of whole
// frames. It then closes the path, freezes the picture and publishes the
// bank display mask. While a capture is running it also checks line and
// frame geometry.
module slant_cap_sched #(
  parameter int H_PIX   = 640,
  parameter int V_LINES = 480,
  parameter int FCNT_W  = 8
) (
  input  logic              Cclk,
  input  logic              rstn,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [FCNT_W-1:0] cmd_frames,
  input  logic [3:0]        cmd_mask,
  input  logic              s_axis_video_tvalid,
  input  logic              s_axis_video_tready,
  input  logic              s_axis_video_tuser,
  input  logic              s_axis_video_tlast,
  output logic              cap_en,
  output logic [3:0]        mem_cont,
  output logic              busy,
  output logic              frame_done,
  output logic              cap_done,
  output logic              err_geom,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam logic [9:0]        H_PIX_C   = 10'(H_PIX);
  localparam logic [8:0]        V_LINES_C = 9'(V_LINES);
  localparam logic [8:0]        LINE_MAX  = 9'd511;
  localparam logic [FCNT_W-1:0] FCNT_ZERO = {FCNT_W{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_ONE  = {{(FCNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   frames_q, frames_d;
  logic [3:0]          mask_q, mask_d;
  logic [9:0]          pix_cnt_q, pix_cnt_d;
  logic [8:0]          line_cnt_q, line_cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                err_q, err_d;
  logic [3:0]          mem_cont_q, mem_cont_d;
  logic                frame_done_q, frame_done_d;
  logic                cap_done_q, cap_done_d;
  logic                busy_q, busy_d;

  logic                beat_s, sof_s, eol_s;
  logic                cap_en_s;
  logic [FCNT_W-1:0]   frame_inc_s;
  logic [9:0]          pix_base_s, pix_next_s;
  logic [8:0]          line_base_s, line_next_s;
  logic                eol_bad_s, sof_bad_s;

  assign beat_s = s_axis_video_tvalid & s_axis_video_tready;
  assign sof_s  = beat_s & s_axis_video_tuser;
  assign eol_s  = beat_s & s_axis_video_tlast;

  // Counter arithmetic for one beat. A sof restarts the counters first, so
  // the sof beat itself counts as pixel 0 of the new frame (also on one-pixel lines).
  always_comb begin
    frame_inc_s = frame_cnt_q + FCNT_ONE;
    pix_base_s  = sof_s ? 10'd0 : pix_cnt_q;
    line_base_s = sof_s ? 9'd0 : line_cnt_q;
    sof_bad_s   = (line_cnt_q != V_LINES_C) || (pix_cnt_q != 10'd0);
    if (eol_s) begin
      pix_next_s  = 10'd0;
      line_next_s = (line_base_s == LINE_MAX) ? LINE_MAX : (line_base_s + 9'd1);
      eol_bad_s   = ((pix_base_s + 10'd1) != H_PIX_C);
    end else begin
      pix_next_s  = pix_base_s + 10'd1;
      line_next_s = line_base_s;
      eol_bad_s   = 1'b0;
    end
  end

  // Next-state and next-output logic for the capture sequencer.
  always_comb begin
    state_d      = state_q;
    frames_d     = frames_q;
    mask_d       = mask_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q;
    mem_cont_d   = mem_cont_q;
    frame_done_d = 1'b0;
    cap_done_d   = 1'b0;
    cap_en_s     = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (cmd_abort) begin
          // Aborting a frozen picture keeps the published mask.
          state_d = ST_IDLE;
        end else if (cmd_start) begin
          frames_d    = (cmd_frames == FCNT_ZERO) ? FCNT_ONE : cmd_frames;
          mask_d      = cmd_mask;
          frame_cnt_d = FCNT_ZERO;
          err_d       = 1'b0;
          mem_cont_d  = 4'h0;
          state_d     = ST_ARM;
        end else begin
          state_d = state_q;
        end
      end
      ST_ARM: begin
        if (cmd_abort) begin
          mem_cont_d = 4'h0;
          state_d    = ST_IDLE;
        end else if (sof_s) begin
          // Open the gate on the sof beat so the first pixel is written.
          cap_en_s   = 1'b1;
          pix_cnt_d  = pix_next_s;
          line_cnt_d = line_next_s;
          err_d      = err_q | eol_bad_s;
          state_d    = ST_CAPTURE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_CAPTURE: begin
        if (cmd_abort) begin
          mem_cont_d = 4'h0;
          state_d    = ST_IDLE;
        end else if (sof_s) begin
          // Close the previous frame before this beat opens the next one.
          err_d        = err_q | sof_bad_s;
          frame_cnt_d  = frame_inc_s;
          frame_done_d = 1'b1;
          if (frame_inc_s == frames_q) begin
            // This sof starts an uncaptured frame, so the gate stays shut.
            cap_done_d = 1'b1;
            mem_cont_d = mask_q;
            state_d    = ST_HOLD;
          end else begin
            cap_en_s   = 1'b1;
            pix_cnt_d  = pix_next_s;
            line_cnt_d = line_next_s;
            err_d      = err_q | sof_bad_s | eol_bad_s;
          end
        end else if (beat_s) begin
          cap_en_s   = 1'b1;
          pix_cnt_d  = pix_next_s;
          line_cnt_d = line_next_s;
          err_d      = err_q | eol_bad_s;
        end else begin
          cap_en_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, cleared asynchronously by rstn.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      frames_q     <= FCNT_ZERO;
      mask_q       <= 4'h0;
      pix_cnt_q    <= 10'd0;
      line_cnt_q   <= 9'd0;
      frame_cnt_q  <= FCNT_ZERO;
      err_q        <= 1'b0;
      mem_cont_q   <= 4'h0;
      frame_done_q <= 1'b0;
      cap_done_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frames_q     <= frames_d;
      mask_q       <= mask_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      mem_cont_q   <= mem_cont_d;
      frame_done_q <= frame_done_d;
      cap_done_q   <= cap_done_d;
      busy_q       <= busy_d;
    end
  end

  assign cap_en     = cap_en_s;
  assign mem_cont   = mem_cont_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cap_done   = cap_done_q;
  assign err_geom   = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
